// File: rtl/aes128_enc_top.sv
// rtl/aes128_enc_top.sv - iterative AES-128 encrypt core, one round per clock; macro AES_DATA_OUT_COMPLEMENTARY_EN adds complementary outputs
`timescale 1ns/1ps

module aes128_enc_top #(
   parameter int NR = 10
) (
   input  logic         AES_clk,
   input  logic         AES_rst_n,
   input  logic         AES_en,
   input  logic [127:0] AES_data_in,
   input  logic [127:0] AES_key_in,
   output logic [127:0] AES_data_out,
   output logic         AES_data_out_valid
`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
   ,
   output logic [127:0] AES_data_out_complementary,
   output logic         AES_data_out_complementary_valid
`endif
);

   typedef enum logic {IDLE, RUN} fsm_t;

   fsm_t         fsm_q;
   logic [127:0] state_q;
   logic [127:0] rkey_q;
   logic [3:0]   cnt_q;

   logic [127:0] rkey_next;
   logic [127:0] sub_bytes;
   logic [127:0] shift_rows;
   logic [127:0] mix_cols;
   logic [127:0] state_next;
   logic [31:0]  key_temp;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the affine transform
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Key schedule: derive round key r from round key r-1 (RotWord, SubWord, Rcon[r])
   always_comb begin
      key_temp = {sbox(rkey_q[23:16]), sbox(rkey_q[15:8]), sbox(rkey_q[7:0]), sbox(rkey_q[31:24])}
                 ^ {rcon(cnt_q), 24'h000000};
      rkey_next[127:96] = rkey_q[127:96] ^ key_temp;
      rkey_next[95:64]  = rkey_q[95:64]  ^ rkey_next[127:96];
      rkey_next[63:32]  = rkey_q[63:32]  ^ rkey_next[95:64];
      rkey_next[31:0]   = rkey_q[31:0]   ^ rkey_next[63:32];
   end

   // Round datapath; byte 4c+r sits at bits [127-8*(4c+r) -: 8], and the last round skips MixColumns
   always_comb begin
      sub_bytes  = '0;
      shift_rows = '0;
      mix_cols   = '0;
      for (int i = 0; i < 16; i++) begin
         sub_bytes[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shift_rows[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mix_cols[127-32*c -: 32] = mix_column(shift_rows[127-32*c -: 32]);
      end
      state_next = ((cnt_q == 4'(NR)) ? shift_rows : mix_cols) ^ rkey_next;
   end

   // Control FSM plus state/key/output registers; the valid strobe defaults low every cycle
   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         fsm_q              <= IDLE;
         state_q            <= '0;
         rkey_q             <= '0;
         cnt_q              <= '0;
         AES_data_out       <= '0;
         AES_data_out_valid <= 1'b0;
`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
         AES_data_out_complementary <= '1;
`endif
      end else begin
         AES_data_out_valid <= 1'b0;
         case (fsm_q)
            IDLE: begin
               if (AES_en) begin
                  state_q <= AES_data_in ^ AES_key_in;
                  rkey_q  <= AES_key_in;
                  cnt_q   <= 4'd1;
                  fsm_q   <= RUN;
               end
            end
            RUN: begin
               state_q <= state_next;
               rkey_q  <= rkey_next;
               if (cnt_q == 4'(NR)) begin
                  AES_data_out       <= state_next;
                  AES_data_out_valid <= 1'b1;
`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
                  AES_data_out_complementary <= ~state_next;
`endif
                  cnt_q <= 4'd0;
                  fsm_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
   assign AES_data_out_complementary_valid = AES_data_out_valid;
`endif

endmodule

// File: tb/tb_aes128_enc_top.sv
// tb/tb_aes128_enc_top.sv - scoreboard bench for aes128_enc_top with directed vectors
`timescale 1ns/1ps

module tb_aes128_enc_top;

   logic         AES_clk;
   logic         AES_rst_n;
   logic         AES_en;
   logic [127:0] AES_data_in;
   logic [127:0] AES_key_in;
   logic [127:0] AES_data_out;
   logic         AES_data_out_valid;
`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
   logic [127:0] AES_data_out_complementary;
   logic         AES_data_out_complementary_valid;
`endif

   aes128_enc_top #(.NR(10)) dut (
      .AES_clk            (AES_clk),
      .AES_rst_n          (AES_rst_n),
      .AES_en             (AES_en),
      .AES_data_in        (AES_data_in),
      .AES_key_in         (AES_key_in),
      .AES_data_out       (AES_data_out),
      .AES_data_out_valid (AES_data_out_valid)
`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
      ,
      .AES_data_out_complementary       (AES_data_out_complementary),
      .AES_data_out_complementary_valid (AES_data_out_complementary_valid)
`endif
   );

   typedef struct {
      logic [127:0] data;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] KEY_H  = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
   localparam logic [127:0] PT_H   = 128'h0000008f000000000000000000000000;

   logic [2047:0] sbox_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sb(input logic [7:0] x);
      return sbox_flat[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic       hi;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   // Reference encryption: full key expansion up front, table S-box, matrix MixColumns
   function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0]   s[16];
      logic [7:0]   t[16];
      logic [31:0]  w[44];
      logic [7:0]   coef[4];
      logic [7:0]   rc;
      logic [7:0]   acc;
      logic [31:0]  tmp;
      logic [127:0] res;
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sb(s[i]);
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
         for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
               if (rnd < 10) begin
                  acc = 8'h00;
                  for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-r+4)%4], t[4*c+j]);
                  s[4*c+r] = acc;
               end else begin
                  s[4*c+r] = t[4*c+r];
               end
            end
         end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s got %h required %h", name, got, exp);
   endtask

   initial AES_clk = 1'b0;
   always #5 AES_clk = ~AES_clk;

   // Count rising edges so the monitor can verify completion latency
   always @(posedge AES_clk) cyc <= cyc + 1;

   // Monitor: every valid pulse pops one expected result and checks data and arrival cycle
   always @(negedge AES_clk) begin
      if (AES_rst_n && AES_data_out_valid) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_valid got pulse with data %h required no pulse", AES_data_out);
         end else begin
            mon_e = exp_q.pop_front();
            check("ciphertext", AES_data_out, mon_e.data);
            check("latency_cycle", 128'(cyc), 128'(mon_e.cyc));
`ifdef AES_DATA_OUT_COMPLEMENTARY_EN
            check("complementary", AES_data_out_complementary, ~mon_e.data);
            check("complementary_valid", 128'(AES_data_out_complementary_valid), 128'd1);
`endif
         end
      end
   end

   // One-cycle start pulse; capture happens on the next rising edge, valid 10 edges later
   task automatic issue(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] exp, input bit push);
      exp_t e;
      @(negedge AES_clk);
      AES_data_in = pt;
      AES_key_in  = key;
      AES_en      = 1'b1;
      e.data = exp;
      e.cyc  = cyc + 11;
      if (push) exp_q.push_back(e);
      @(negedge AES_clk);
      AES_en = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge AES_clk);
         n++;
      end
      @(negedge AES_clk);
      if (exp_q.size() != 0) begin
         total_cnt++;
         $display("FAIL drain_timeout got %0d pending results required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      exp_t         e;
      int           base;
      logic [127:0] ct_h;
      logic [127:0] chg[3];

      AES_rst_n   = 1'b0;
      AES_en      = 1'b0;
      AES_data_in = '0;
      AES_key_in  = '0;
      repeat (2) @(negedge AES_clk);
      check("reset_data_out", AES_data_out, 128'h0);
      check("reset_valid", 128'(AES_data_out_valid), 128'h0);
      AES_rst_n = 1'b1;
      @(negedge AES_clk);
      check("idle_data_out", AES_data_out, 128'h0);

      issue(PT_C1, KEY_C1, CT_C1, 1'b1);
      wait_drain(40);
      issue(PT_B, KEY_B, CT_B, 1'b1);
      wait_drain(40);
      issue(128'h0, 128'h0, CT_Z, 1'b1);
      wait_drain(40);

      // Inputs and AES_en wiggle mid-run; result must still be the captured vector
      issue(PT_C1, KEY_C1, CT_C1, 1'b1);
      repeat (5) begin
         @(negedge AES_clk);
         AES_en      = 1'b1;
         AES_data_in = {$urandom, $urandom, $urandom, $urandom};
         AES_key_in  = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge AES_clk);
      AES_en = 1'b0;
      wait_drain(40);

      // AES_en held high for 51 edges: five starts, one every 11 cycles
      ct_h = aes_model(PT_H, KEY_H);
      @(negedge AES_clk);
      AES_data_in = PT_H;
      AES_key_in  = KEY_H;
      AES_en      = 1'b1;
      base = cyc;
      for (int j = 0; j < 5; j++) begin
         e.data = ct_h;
         e.cyc  = base + 11 + 11*j;
         exp_q.push_back(e);
      end
      repeat (51) @(negedge AES_clk);
      AES_en = 1'b0;
      wait_drain(80);

      chg[0] = 128'ha6f2daeb000000000000000000000000;
      chg[1] = 128'hd7b26248000000000000000000000000;
      chg[2] = 128'hf301a68a000000000000000000000000;
      for (int j = 0; j < 3; j++) begin
         AES_data_in = chg[j];
         repeat (15) @(negedge AES_clk);
         check("hold_data_out", AES_data_out, ct_h);
      end

      // Reset asserted around round 5 aborts the run with no pulse
      issue(PT_B, KEY_B, CT_B, 1'b0);
      repeat (4) @(posedge AES_clk);
      #2;
      AES_rst_n = 1'b0;
      #1;
      check("abort_data_out", AES_data_out, 128'h0);
      check("abort_valid", 128'(AES_data_out_valid), 128'h0);
      repeat (15) @(negedge AES_clk);
      check("abort_no_pulse_data", AES_data_out, 128'h0);
      AES_rst_n = 1'b1;
      issue(PT_C1, KEY_C1, CT_C1, 1'b1);
      wait_drain(40);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout got time limit required completion");
      $fatal(1, "timeout");
   end

endmodule
